// File: rtl/seg7_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundles the scanned display bus and the decoded results of the
// seven-segment scan decoder.
//   master : drives the display bus and err_clear, observes the results
//   slave  : the decoder; samples the bus, drives the results
// Signals:
//   segmento_input  [6:0]            segments {g,f,e,d,c,b,a}, active-low
//   digit_en_input  [NUM_DIGITS-1:0] digit enables, active-low, digit 0 = LSB
//   err_clear                        one-cycle pulse clearing sticky flags
//   bcd_output      [4*NUM_DIGITS-1:0] recovered digits, digit i at [4i+3:4i]
//   digit_blank     [NUM_DIGITS-1:0] digit last captured as blank
//   frame_valid                      one-cycle pulse per completed frame
//   pattern_err / multi_en_err / stall_flag   sticky error flags
// ---------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              segmento_input;
  logic [NUM_DIGITS-1:0]   digit_en_input;
  logic                    err_clear;
  logic [4*NUM_DIGITS-1:0] bcd_output;
  logic [NUM_DIGITS-1:0]   digit_blank;
  logic                    frame_valid;
  logic                    pattern_err;
  logic                    multi_en_err;
  logic                    stall_flag;

  modport master (
    output segmento_input, digit_en_input, err_clear,
    input  bcd_output, digit_blank, frame_valid,
           pattern_err, multi_en_err, stall_flag
  );

  modport slave (
    input  segmento_input, digit_en_input, err_clear,
    output bcd_output, digit_blank, frame_valid,
           pattern_err, multi_en_err, stall_flag
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
// Receives a multiplexed, scanned seven-segment display bus and recovers the
// BCD digit shown on each position. The bus is synchronized, filtered for
// STABLE_CYCLES identical samples, then captured once per stable word.
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-low reset
//   bus    seg7_scan_decoder_if.slave (display bus in, decoded results out)
// Parameters:
//   NUM_DIGITS      number of scanned digits
//   STABLE_CYCLES   identical synchronized samples required (1..255)
//   TIMEOUT_CYCLES  capture-free cycles before stall_flag (1..2^20-1)
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_decoder_if.slave  bus
);

  localparam int              W       = 7 + NUM_DIGITS;
  localparam logic [7:0]      STB_M1  = 8'(STABLE_CYCLES - 1);
  localparam logic [19:0]     TMO     = 20'(TIMEOUT_CYCLES);
  localparam logic [19:0]     TMO_M1  = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] EN_ONE  = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] EN_ZERO = {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] EN_ALL  = {NUM_DIGITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Inverse of the active-low BCD drive table; blank -> F, anything else -> E.
  function automatic logic [3:0] decode_seg(input logic [6:0] seg);
    logic [3:0] val;
    case (seg)
      7'b1000000: val = 4'h0;
      7'b1111001: val = 4'h1;
      7'b0100100: val = 4'h2;
      7'b0110000: val = 4'h3;
      7'b0011001: val = 4'h4;
      7'b0010010: val = 4'h5;
      7'b0000010: val = 4'h6;
      7'b1111000: val = 4'h7;
      7'b0000000: val = 4'h8;
      7'b0010000: val = 4'h9;
      7'b1111111: val = 4'hF;
      default:    val = 4'hE;
    endcase
    return val;
  endfunction

  logic [W-1:0]            sync1_q, sync2_q, prev_q;
  logic [7:0]              cnt_q, cnt_d;
  logic [19:0]             tcnt_q, tcnt_d;
  state_t                  state_q;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    fv_q, fv_d;
  logic                    perr_q, perr_d;
  logic                    merr_q, merr_d;
  logic                    stall_q, stall_d;

  logic [6:0]              seg_s;
  logic [NUM_DIGITS-1:0]   en_low_s;
  logic                    changed_s, any_low_s, one_hot_s;
  logic                    capture_pt_s, do_capture_s, multi_hit_s;
  logic [3:0]              dec_val_s;
  logic                    is_blank_s;
  logic [NUM_DIGITS-1:0]   mask_or_s;

  // Two-flop synchronizer plus previous-sample register; all-ones is "dark".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= {W{1'b1}};
      sync2_q <= {W{1'b1}};
      prev_q  <= {W{1'b1}};
      cnt_q   <= 8'd0;
      tcnt_q  <= 20'd0;
    end else begin
      sync1_q <= {bus.segmento_input, bus.digit_en_input};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Stability/timeout counters, capture qualification and next flag values.
  always_comb begin
    seg_s        = sync2_q[W-1:NUM_DIGITS];
    en_low_s     = ~sync2_q[NUM_DIGITS-1:0];
    changed_s    = (sync2_q != prev_q);
    any_low_s    = (en_low_s != EN_ZERO);
    one_hot_s    = any_low_s && ((en_low_s & (en_low_s - EN_ONE)) == EN_ZERO);
    // cnt restarts on every change, so entering SETTLE always starts at 0.
    capture_pt_s = (state_q == SETTLE) && any_low_s && !changed_s && (cnt_q >= STB_M1);
    do_capture_s = capture_pt_s && one_hot_s;
    multi_hit_s  = capture_pt_s && !one_hot_s;
    dec_val_s    = decode_seg(seg_s);
    is_blank_s   = (seg_s == 7'b1111111);

    if (changed_s) begin
      cnt_d = 8'd0;
    end else if (cnt_q == 8'hFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    // stall is raised only on the edge the count reaches the limit, so a
    // clear while saturated sticks until the next capture-free run.
    if (do_capture_s) begin
      tcnt_d = 20'd0;
    end else if (tcnt_q == TMO) begin
      tcnt_d = tcnt_q;
    end else begin
      tcnt_d = tcnt_q + 20'd1;
    end

    if (do_capture_s) begin
      mask_or_s = mask_q | en_low_s;
    end else begin
      mask_or_s = mask_q;
    end
    if (mask_or_s == EN_ALL) begin
      mask_d = EN_ZERO;
      fv_d   = 1'b1;
    end else begin
      mask_d = mask_or_s;
      fv_d   = 1'b0;
    end

    // Set has priority over err_clear.
    perr_d  = (do_capture_s && (dec_val_s == 4'hE)) || (perr_q && !bus.err_clear);
    merr_d  = multi_hit_s || (merr_q && !bus.err_clear);
    stall_d = (!do_capture_s && (tcnt_q == TMO_M1)) || (stall_q && !bus.err_clear);
  end

  // Scan FSM with its registered capture results and flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= EN_ZERO;
      bcd_q   <= {NUM_DIGITS{4'hF}};
      blank_q <= EN_ALL;
      fv_q    <= 1'b0;
      perr_q  <= 1'b0;
      merr_q  <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_low_s) state_q <= SETTLE;
          else           state_q <= IDLE;
        end
        SETTLE: begin
          if (!any_low_s)        state_q <= IDLE;
          else if (capture_pt_s) state_q <= HOLD;
          else                   state_q <= SETTLE;
        end
        HOLD: begin
          if (!any_low_s)     state_q <= IDLE;
          else if (changed_s) state_q <= SETTLE;
          else                state_q <= HOLD;
        end
        default: state_q <= IDLE;
      endcase

      if (do_capture_s) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (en_low_s[i]) begin
            bcd_q[4*i +: 4] <= dec_val_s;
            blank_q[i]      <= is_blank_s;
          end
        end
      end

      mask_q  <= mask_d;
      fv_q    <= fv_d;
      perr_q  <= perr_d;
      merr_q  <= merr_d;
      stall_q <= stall_d;
    end
  end

  assign bus.bcd_output   = bcd_q;
  assign bus.digit_blank  = blank_q;
  assign bus.frame_valid  = fv_q;
  assign bus.pattern_err  = perr_q;
  assign bus.multi_en_err = merr_q;
  assign bus.stall_flag   = stall_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed scenarios for the seven-segment scan decoder (STABLE_CYCLES = 4,
// TIMEOUT_CYCLES = 20). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so a word driven before edge N
// shows up after edge N+6 (7 edges of latency).
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus();

  seg7_scan_decoder #(
    .NUM_DIGITS(4),
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] e);
    bus.segmento_input = s;
    bus.digit_en_input = e;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.err_clear = 1'b0;
    drive(7'h7F, 4'hF);
    repeat (2) tick();
    reset = 1'b1;
  endtask

  // Presents one digit for n cycles and records frame_valid pulses.
  task automatic scan_digit(input int idx, input logic [6:0] s, input int n,
                            output int fv_n, output int fv_t);
    logic [3:0] en;
    en = ~(4'b0001 << idx);
    drive(s, en);
    fv_n = 0;
    fv_t = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (bus.frame_valid === 1'b1) begin
        fv_n++;
        fv_t = t;
      end
    end
  endtask

  task automatic test_reset();
    bus.err_clear = 1'b0;
    drive(7'h7F, 4'hF);
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({bus.bcd_output, bus.digit_blank} !== {16'hFFFF, 4'hF}) begin
      errors++;
      $display("FAIL reset_values: got bcd=%h blank=%b expected bcd=ffff blank=1111",
               bus.bcd_output, bus.digit_blank);
    end
    checks++;
    if ({bus.frame_valid, bus.pattern_err, bus.multi_en_err, bus.stall_flag} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.frame_valid, bus.pattern_err, bus.multi_en_err, bus.stall_flag});
    end
  endtask

  task automatic test_scan_frame();
    int n0, n1, n2, n3, t0, t1, t2, t3;
    do_reset();
    scan_digit(0, 7'h79, 10, n0, t0);
    scan_digit(1, 7'h24, 10, n1, t1);
    scan_digit(2, 7'h30, 10, n2, t2);
    scan_digit(3, 7'h19, 10, n3, t3);
    checks++;
    if (bus.bcd_output !== 16'h4321) begin
      errors++;
      $display("FAIL scan_bcd: got %h expected 4321", bus.bcd_output);
    end
    checks++;
    if ((n0 + n1 + n2) !== 0 || n3 !== 1 || t3 !== 7) begin
      errors++;
      $display("FAIL scan_frame_valid: got early=%0d last=%0d at_edge=%0d expected 0 1 7",
               n0 + n1 + n2, n3, t3);
    end
    checks++;
    if ({bus.digit_blank, bus.pattern_err, bus.multi_en_err, bus.stall_flag} !== 7'b0000000) begin
      errors++;
      $display("FAIL scan_flags: got blank=%b perr=%b merr=%b stall=%b expected all 0",
               bus.digit_blank, bus.pattern_err, bus.multi_en_err, bus.stall_flag);
    end
  endtask

  task automatic test_glitch();
    int hits;
    logic [6:0] s;
    do_reset();
    hits = 0;
    s = 7'h24;
    for (int k = 0; k < 6; k++) begin
      drive(s, 4'b1101);
      repeat (2) begin
        tick();
        if (bus.bcd_output[7:4] !== 4'hF) hits++;
      end
      s = (s == 7'h24) ? 7'h30 : 7'h24;
    end
    checks++;
    if (hits !== 0) begin
      errors++;
      $display("FAIL glitch_no_capture: got %0d captured samples expected 0", hits);
    end
    drive(7'h10, 4'b1101);
    repeat (6) tick();
    checks++;
    if (bus.bcd_output[7:4] !== 4'hF) begin
      errors++;
      $display("FAIL glitch_early: got %h expected f after 6 edges", bus.bcd_output[7:4]);
    end
    tick();
    checks++;
    if (bus.bcd_output[7:4] !== 4'h9) begin
      errors++;
      $display("FAIL glitch_capture: got %h expected 9 after 7 edges", bus.bcd_output[7:4]);
    end
  endtask

  task automatic test_multi_enable();
    int n, t, fv;
    do_reset();
    scan_digit(0, 7'h12, 10, n, t);
    drive(7'h79, 4'b1100);
    repeat (6) tick();
    checks++;
    if (bus.multi_en_err !== 1'b0) begin
      errors++;
      $display("FAIL multi_early: got %b expected 0", bus.multi_en_err);
    end
    fv = 0;
    tick();
    checks++;
    if (bus.multi_en_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_set: got %b expected 1", bus.multi_en_err);
    end
    repeat (3) begin
      tick();
      if (bus.frame_valid === 1'b1) fv++;
    end
    checks++;
    if (bus.bcd_output !== 16'hFFF5 || fv !== 0) begin
      errors++;
      $display("FAIL multi_no_update: got bcd=%h fv=%0d expected fff5 0", bus.bcd_output, fv);
    end
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    checks++;
    if (bus.multi_en_err !== 1'b0) begin
      errors++;
      $display("FAIL multi_clear: got %b expected 0", bus.multi_en_err);
    end
  endtask

  task automatic test_pattern_blank();
    int n, t;
    do_reset();
    drive(7'h55, 4'b1011);
    repeat (6) tick();
    checks++;
    if (bus.pattern_err !== 1'b0) begin
      errors++;
      $display("FAIL pattern_early: got %b expected 0", bus.pattern_err);
    end
    tick();
    checks++;
    if ({bus.pattern_err, bus.bcd_output[11:8], bus.digit_blank[2]} !== {1'b1, 4'hE, 1'b0}) begin
      errors++;
      $display("FAIL pattern_err: got perr=%b d2=%h blank2=%b expected 1 e 0",
               bus.pattern_err, bus.bcd_output[11:8], bus.digit_blank[2]);
    end
    repeat (3) tick();
    scan_digit(3, 7'h00, 10, n, t);
    checks++;
    if ({bus.bcd_output[15:12], bus.digit_blank[3]} !== {4'h8, 1'b0}) begin
      errors++;
      $display("FAIL digit3_eight: got d3=%h blank3=%b expected 8 0",
               bus.bcd_output[15:12], bus.digit_blank[3]);
    end
    scan_digit(3, 7'h7F, 7, n, t);
    checks++;
    if ({bus.bcd_output, bus.digit_blank, bus.pattern_err} !== {16'hFEFF, 4'b1011, 1'b1}) begin
      errors++;
      $display("FAIL digit3_blank: got bcd=%h blank=%b perr=%b expected feff 1011 1",
               bus.bcd_output, bus.digit_blank, bus.pattern_err);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (19) tick();
    checks++;
    if (bus.stall_flag !== 1'b0) begin
      errors++;
      $display("FAIL stall_early: got %b expected 0 after 19 idle edges", bus.stall_flag);
    end
    tick();
    checks++;
    if (bus.stall_flag !== 1'b1) begin
      errors++;
      $display("FAIL stall_set: got %b expected 1 after 20 idle edges", bus.stall_flag);
    end
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.stall_flag !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear: got %b expected 0", bus.stall_flag);
    end
    do_reset();
    repeat (19) tick();
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    checks++;
    if (bus.stall_flag !== 1'b1) begin
      errors++;
      $display("FAIL stall_set_wins: got %b expected 1", bus.stall_flag);
    end
  endtask

  task automatic test_reset_midframe();
    int n0, n1, n2, n3, t0, t1, t2, t3;
    do_reset();
    scan_digit(0, 7'h40, 10, n0, t0);
    scan_digit(1, 7'h79, 10, n1, t1);
    checks++;
    if (bus.bcd_output[7:0] !== 8'h10) begin
      errors++;
      $display("FAIL pre_reset_digits: got %h expected 10", bus.bcd_output[7:0]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.bcd_output, bus.digit_blank, bus.frame_valid, bus.pattern_err,
         bus.multi_en_err, bus.stall_flag} !== {16'hFFFF, 4'hF, 4'b0000}) begin
      errors++;
      $display("FAIL midframe_reset: got bcd=%h blank=%b flags=%b expected ffff 1111 0000",
               bus.bcd_output, bus.digit_blank,
               {bus.frame_valid, bus.pattern_err, bus.multi_en_err, bus.stall_flag});
    end
    drive(7'h7F, 4'hF);
    repeat (2) tick();
    reset = 1'b1;
    scan_digit(2, 7'h78, 10, n2, t2);
    scan_digit(3, 7'h00, 10, n3, t3);
    scan_digit(0, 7'h12, 10, n0, t0);
    scan_digit(1, 7'h02, 10, n1, t1);
    checks++;
    if ((n2 + n3 + n0) !== 0 || n1 !== 1 || t1 !== 7) begin
      errors++;
      $display("FAIL post_reset_frame: got early=%0d last=%0d at_edge=%0d expected 0 1 7",
               n2 + n3 + n0, n1, t1);
    end
    checks++;
    if (bus.bcd_output !== 16'h8765) begin
      errors++;
      $display("FAIL post_reset_bcd: got %h expected 8765", bus.bcd_output);
    end
  endtask

  initial begin
    test_reset();
    test_scan_frame();
    test_glitch();
    test_multi_enable();
    test_pattern_blank();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reads a multiplexed, scanned 7-segment display bus (active-low segments, active-low digit enables) and recovers the BCD value shown on each digit.
- It is the receive end of the team's BCD-to-7-segment drive path. It is used as an on-chip display monitor, a loopback checker in self-test, and a decoder for external display buses.
- Requires a glitch filter plus a per-frame valid handshake toward the consumer.

Parameters:
- NUM_DIGITS, 4, number of scanned digits; sets the width of the enable and BCD buses.
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture; range 1..255.
- TIMEOUT_CYCLES, 65535, cycles without a capture before stall_flag is set; range 1..2^20-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- segmento_input  input  7  segment lines {g,f,e,d,c,b,a}, active-low.
- digit_en_input  input  NUM_DIGITS  digit enables, active-low, digit 0 = LSB.
- err_clear  input  1  synchronous one-cycle pulse; clears the sticky flags.
- bcd_output  output  4*NUM_DIGITS  recovered digits, digit i at bits [4i+3:4i].
- digit_blank  output  NUM_DIGITS  digit i was last captured as blank (7'b1111111).
- frame_valid  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- pattern_err  output  1  sticky: a non-BCD, non-blank pattern was captured.
- multi_en_err  output  1  sticky: a stable sample had more than one enable low.
- stall_flag  output  1  sticky: TIMEOUT_CYCLES elapsed without a capture.

Behaviour:
- Reset values (while reset low, asynchronous):
  - bcd_output = all 4'hF; digit_blank = all 1.
  - frame_valid, pattern_err, multi_en_err, stall_flag = 0.
  - Captured-mask = 0; counters = 0; FSM = IDLE.
  - Synchronizers reset to all-ones (display dark).
- Input path:
  - {segmento_input, digit_en_input} passes through a two-flop synchronizer (stage s2).
  - A prev register holds s2 from the previous cycle.
- Stability counter cnt (8 bits, saturating at 255):
  - Cleared to 0 on any edge where s2 != prev.
  - Otherwise incremented.
- FSM:
  - IDLE: no enable low in s2. Go to SETTLE when s2 has at least one enable low.
  - SETTLE: wait while cnt < STABLE_CYCLES-1. On the edge where cnt == STABLE_CYCLES-1 and s2 == prev, perform a capture (or flag a multi-enable error) and go to HOLD.
  - HOLD: no further captures. Return to SETTLE on any change (s2 != prev), or to IDLE if all enables are high.
- Latency: an input word held constant appears on the outputs exactly STABLE_CYCLES+3 rising edges after it is first presented.
- Capture rules (exactly one enable low, digit i):
  - Decode the segment pattern with the inverse of the standard active-low table:
    - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
    - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
  - 1111111: bcd = 4'hF, digit_blank[i] = 1, no error.
  - Any other pattern: bcd = 4'hE, digit_blank[i] = 0, pattern_err set.
  - Set captured-mask[i]; reset the timeout counter.
- Multiple enables low at the capture point: no digit is updated and the mask is unchanged; multi_en_err is set.
- Frame completion:
  - On the edge the mask becomes all-ones, frame_valid = 1 for exactly one cycle and the mask is cleared in the same edge.
  - Re-capturing an already-masked digit is allowed; the digit's value updates and the mask is unchanged.
- Timeout: the counter increments on every cycle without a capture. On reaching TIMEOUT_CYCLES it sets stall_flag and saturates.
- err_clear clears pattern_err, multi_en_err, stall_flag. If a set event and err_clear occur in the same cycle, set wins.
- Reset asserted mid-frame: all state returns immediately to reset values, and the partial frame is discarded.

Test Plan:
1. Scan digits 0..3 with patterns for 1,2,3,4, each held 10 cycles.
   - bcd_output = 16'h4321.
   - frame_valid pulses once, at STABLE_CYCLES+3 edges after digit 3's word appears.
   - No flags set.
2. Digit 1 pattern toggles every 2 cycles (glitch), then holds 0010000.
   - No capture during toggling.
   - Digit 1 = 9 exactly 7 edges after the final hold begins.
3. digit_en_input = 4'b1100, stable.
   - multi_en_err = 1; bcd_output unchanged; no frame_valid.
   - err_clear pulse returns the flag to 0.
4. Capture pattern 1010101 on digit 2, then 1111111 on digit 3.
   - Digit 2 = 4'hE and pattern_err = 1.
   - Digit 3 = 4'hF and digit_blank[3] = 1.
5. TIMEOUT_CYCLES = 20; hold all enables high.
   - stall_flag rises on the 20th idle cycle.
   - err_clear in the same cycle as the set leaves stall_flag = 1.
6. Assert reset after digits 0-1 are captured, release, then scan all 4 digits.
   - Outputs return to reset values immediately.
   - A single frame_valid occurs only after all 4 digits are captured post-reset.
